regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Optional feature macro used by the top: WB_ARB_BYPASS_EN.
package regfile_wb_pkg;

   localparam int NUM_REGS_DEF   = 32;
   localparam int DATA_WIDTH_DEF = 64;
   localparam int ADDR_WIDTH_DEF = 5;

   localparam logic [ADDR_WIDTH_DEF-1:0] REG_ZERO = 5'd0;

   // One write-back request: destination register and the value to write.
   typedef struct packed {
      logic [ADDR_WIDTH_DEF-1:0] rd;
      logic [DATA_WIDTH_DEF-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: picks the first set request at or after
// rr_ptr (wrapping), and moves rr_ptr past the winner when advance is high.
module rr_arbiter #(
   parameter  int NUM_REQ = 3,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [IDX_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] hi_mask;
   logic [NUM_REQ-1:0] req_hi;
   logic [NUM_REQ-1:0] pick_src;
   logic [IDX_W-1:0]   idx_acc [NUM_REQ+1];

   // hi_mask keeps requesters at or above rr_ptr; idx_acc encodes the one-hot grant.
   assign idx_acc[0] = '0;
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bit
      assign hi_mask[g]   = (IDX_W'(g) >= rr_ptr);
      assign idx_acc[g+1] = idx_acc[g] | (grant_onehot[g] ? IDX_W'(g) : '0);
   end

   // Requests above the pointer win; otherwise the search wraps to the bottom.
   assign req_hi       = req & hi_mask;
   assign pick_src     = (|req_hi) ? req_hi : req;
   assign grant_onehot = pick_src & (~pick_src + NUM_REQ'(1));
   assign grant_idx    = idx_acc[NUM_REQ];

   // Pointer moves to the requester after the winner on every accepted transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing the register file's single write port among
// NUM_REQ execution units. Round-robin grant, registered write port, writes
// to x0 are consumed but never reach the register file.
// Optional macro WB_ARB_BYPASS_EN adds a combinational read-forwarding path.
//
// Handshake: a transfer from requester i happens on a rising edge where
// req_valid[i] && req_ready[i]. A requester holds valid, rd and data stable
// until accepted. req_ready depends combinationally on req_valid; req_valid
// must never depend on req_ready.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter  int NUM_REQ    = 3,
   parameter  int NUM_REGS   = NUM_REGS_DEF,
   parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
   localparam int ADDR_WIDTH = $clog2(NUM_REGS),
   localparam int GRANT_W    = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic                          reg_write,
   output logic [ADDR_WIDTH-1:0]         write_register,
   output logic [DATA_WIDTH-1:0]         write_data,
`ifdef WB_ARB_BYPASS_EN
   input  logic [ADDR_WIDTH-1:0]         read_register1,
   input  logic [ADDR_WIDTH-1:0]         read_register2,
   input  logic [DATA_WIDTH-1:0]         rf_read_data1,
   input  logic [DATA_WIDTH-1:0]         rf_read_data2,
   output logic [DATA_WIDTH-1:0]         fwd_data1,
   output logic [DATA_WIDTH-1:0]         fwd_data2,
`endif
   output logic [GRANT_W-1:0]            grant_id
);

   logic [NUM_REQ-1:0]    grant_onehot;
   logic [GRANT_W-1:0]    grant_idx;
   logic                  xfer;
   logic [ADDR_WIDTH-1:0] rd_arr   [NUM_REQ];
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;

   // Split the packed request buses into per-requester entries.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign rd_arr[g]   = req_rd[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req_valid),
      .advance      (xfer),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx)
   );

   // Ready is held low during reset so nothing is consumed that will be lost.
   assign req_ready = grant_onehot & {NUM_REQ{rst_n}};
   assign xfer      = |req_ready;
   assign sel_rd    = rd_arr[grant_idx];
   assign sel_data  = data_arr[grant_idx];

   // Output stage: capture the winner each transfer; enable only for non-x0 targets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write      <= 1'b0;
         write_register <= '0;
         write_data     <= '0;
         grant_id       <= '0;
      end else if (xfer) begin
         reg_write      <= (sel_rd != ADDR_WIDTH'(REG_ZERO));
         write_register <= sel_rd;
         write_data     <= sel_data;
         grant_id       <= grant_idx;
      end else begin
         reg_write      <= 1'b0;
      end
   end

`ifdef WB_ARB_BYPASS_EN
   // Forward the in-flight write to readers of the same non-zero register.
   assign fwd_data1 = (reg_write && (write_register == read_register1) &&
                       (read_register1 != '0)) ? write_data : rf_read_data1;
   assign fwd_data2 = (reg_write && (write_register == read_register2) &&
                       (read_register2 != '0)) ? write_data : rf_read_data2;
`endif

endmodule
